vram_arbiter: RTL and testbench

Owns the single-port video RAM and shares it between the scanout path and two game-side writers (playfield/tile engine and sprite engine). Each `row`/`col` pixel advance from the VGA timing generator triggers one high-priority read slot; every other `clk_50M` cycle is offered to the writers under two-way round-robin. The fetched pixel is returned registered to the colour stage. A `vblank_start` pulse is issued so game logic can schedule bulk updates.

---
 rtl/vga_pkg.sv | 16 +
 rtl/rr_arb2.sv | 34 +++
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM constants and the VRAM slot-owner encoding.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int ADDR_W_DEF   = 19;
   localparam int DATA_W_DEF   = 8;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_VID,
      SLOT_WR0,
      SLOT_WR1
   } slot_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner so that
// two continuous requesters alternate.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Starts at 1 so writer 0 wins the first contested slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM owner: scanout reads take priority on each pixel
// advance, remaining cycles go round-robin to the two writers.
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic [9:0]        row,
   input  logic [9:0]        col,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              vblank_start,
   input  logic              wr0_req,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   output logic              wr0_gnt,
   input  logic              wr1_req,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   output logic              wr1_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

   logic              run;
   logic [9:0]        col_q;
   logic [9:0]        row_q;
   logic              rd_q;
   logic              vid_need;
   logic              vid_slot;
   logic              arb_en;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] vid_addr;
   slot_t             owner;

   assign vid_need = (col != col_q) && (row < V_LIM) && (col < H_LIM);
   assign vid_slot = run && vid_need;
   assign arb_en   = run && !vid_need;
   assign req      = {wr1_req, wr0_req};

   assign vid_addr = ADDR_W'(row) * ADDR_W'(H_ACTIVE) + ADDR_W'(col);

   rr_arb2 u_arb (
      .clk   (clk_50M),
      .reset (reset),
      .en    (arb_en),
      .req   (req),
      .gnt   (gnt)
   );

   always_comb begin
      owner = SLOT_IDLE;
      unique case (1'b1)
         vid_slot: owner = SLOT_VID;
         gnt[0]:   owner = SLOT_WR0;
         gnt[1]:   owner = SLOT_WR1;
         default:  owner = SLOT_IDLE;
      endcase
   end

   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wr0_gnt   = 1'b0;
      wr1_gnt   = 1'b0;
      unique case (owner)
         SLOT_VID: begin
            mem_re   = 1'b1;
            mem_addr = vid_addr;
         end
         SLOT_WR0: begin
            mem_we    = 1'b1;
            mem_addr  = wr0_addr;
            mem_wdata = wr0_data;
            wr0_gnt   = 1'b1;
         end
         SLOT_WR1: begin
            mem_we    = 1'b1;
            mem_addr  = wr1_addr;
            mem_wdata = wr1_data;
            wr1_gnt   = 1'b1;
         end
         default: ;
      endcase
   end

   assign vblank_start = run && (row == V_LIM) && (row_q != V_LIM);

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         run   <= 1'b0;
         col_q <= '0;
         row_q <= '0;
      end else begin
         run   <= 1'b1;
         col_q <= col;
         row_q <= row;
      end
   end

   // Read data arrives one cycle after mem_re; register it once more.
   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         rd_q      <= 1'b0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
      end else begin
         rd_q      <= (owner == SLOT_VID);
         pix_valid <= rd_q;
         if (rd_q) begin
            pix_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table, directed corner sequences and
// a randomized run against a behavioural model.
module tb_vram_arbiter;

   logic        clk;
   logic        reset;
   logic [9:0]  row;
   logic [9:0]  col;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        vblank_start;
   logic        wr0_req;
   logic [18:0] wr0_addr;
   logic [7:0]  wr0_data;
   logic        wr0_gnt;
   logic        wr1_req;
   logic [18:0] wr1_addr;
   logic [7:0]  wr1_data;
   logic        wr1_gnt;
   logic [18:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;

   int n_cmp;
   int n_bad;

   vram_arbiter dut (
      .clk_50M      (clk),
      .reset        (reset),
      .row          (row),
      .col          (col),
      .pix_data     (pix_data),
      .pix_valid    (pix_valid),
      .vblank_start (vblank_start),
      .wr0_req      (wr0_req),
      .wr0_addr     (wr0_addr),
      .wr0_data     (wr0_data),
      .wr0_gnt      (wr0_gnt),
      .wr1_req      (wr1_req),
      .wr1_addr     (wr1_addr),
      .wr1_data     (wr1_data),
      .wr1_gnt      (wr1_gnt),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] vhash(input logic [18:0] a);
      return a[7:0] ^ {a[12:8], 3'b101} ^ a[18:11];
   endfunction

   // VRAM model: content is a fixed function of the address.
   always @(posedge clk) begin
      mem_rdata <= mem_re ? vhash(mem_addr) : 8'hEE;
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      row     = '0;
      col     = '0;
      wr0_req = 1'b0;
      wr1_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      cyc();
   endtask

   typedef struct {
      logic [9:0]  row;
      logic [9:0]  col;
      logic        r0;
      logic        r1;
      logic        re;
      logic        we;
      logic        g0;
      logic        g1;
      logic        vb;
      logic        pv;
      logic [18:0] addr;
      logic [7:0]  wd;
   } vec_t;

   function automatic vec_t mk(input int r, input int c, input int r0,
                               input int r1, input int re, input int we,
                               input int g0, input int g1, input int vb,
                               input int pv, input int a, input int wd);
      vec_t v;
      v.row  = 10'(r);
      v.col  = 10'(c);
      v.r0   = r0[0];
      v.r1   = r1[0];
      v.re   = re[0];
      v.we   = we[0];
      v.g0   = g0[0];
      v.g1   = g1[0];
      v.vb   = vb[0];
      v.pv   = pv[0];
      v.addr = 19'(a);
      v.wd   = 8'(wd);
      return v;
   endfunction

   typedef struct {
      int         due;
      logic [7:0] d;
   } pend_t;

   vec_t  tbl[12];
   pend_t pq[$];
   int    pv_cnt;
   int    vb_cnt;
   int    rowv, colv, m_col, m_row, m_last, win, a;
   bit    fetch, moved, e_re, e_we, e_g0, e_g1, e_vb, e_pv;
   bit    w_req[2];
   logic [18:0] w_addr[2];
   logic [7:0]  w_data[2];
   logic [7:0]  m_pix;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      wr0_addr = 19'h01000;
      wr0_data = 8'h3C;
      wr1_addr = 19'h02000;
      wr1_data = 8'hC3;

      // Reset held with every request high.
      reset   = 1'b0;
      row     = 10'd500;
      col     = 10'd0;
      wr0_req = 1'b1;
      wr1_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_g0", 32'(wr0_gnt), 0);
      check("rst_g1", 32'(wr1_gnt), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_re", 32'(mem_re), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", 32'(mem_wdata), 0);
      check("rst_pv", 32'(pix_valid), 0);
      check("rst_pd", 32'(pix_data), 0);
      check("rst_vb", 32'(vblank_start), 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rel_g0_early", 32'(wr0_gnt), 0);
      check("rel_we_early", 32'(mem_we), 0);
      cyc();
      @(negedge clk);
      check("rel_g0_first", 32'(wr0_gnt), 1);
      check("rel_g1_first", 32'(wr1_gnt), 0);

      // Vector table, applied back to back from a fresh reset.
      tbl[0]  = mk(2, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1285, 0);
      tbl[1]  = mk(2, 6, 1, 1, 1, 0, 0, 0, 0, 0, 1286, 0);
      tbl[2]  = mk(2, 6, 1, 1, 0, 1, 1, 0, 0, 1, 'h1000, 'h3C);
      tbl[3]  = mk(2, 7, 1, 1, 1, 0, 0, 0, 0, 1, 1287, 0);
      tbl[4]  = mk(2, 7, 1, 1, 0, 1, 0, 1, 0, 0, 'h2000, 'hC3);
      tbl[5]  = mk(2, 7, 0, 1, 0, 1, 0, 1, 0, 1, 'h2000, 'hC3);
      tbl[6]  = mk(2, 7, 1, 1, 0, 1, 1, 0, 0, 0, 'h1000, 'h3C);
      tbl[7]  = mk(2, 640, 0, 1, 0, 1, 0, 1, 0, 0, 'h2000, 'hC3);
      tbl[8]  = mk(3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1920, 0);
      tbl[9]  = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(480, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tbl[11] = mk(480, 2, 1, 1, 0, 1, 1, 0, 0, 0, 'h1000, 'h3C);
      do_reset();
      for (int i = 0; i < 12; i++) begin
         row     = tbl[i].row;
         col     = tbl[i].col;
         wr0_req = tbl[i].r0;
         wr1_req = tbl[i].r1;
         @(negedge clk);
         check($sformatf("v%0d_re", i), 32'(mem_re), 32'(tbl[i].re));
         check($sformatf("v%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
         check($sformatf("v%0d_g0", i), 32'(wr0_gnt), 32'(tbl[i].g0));
         check($sformatf("v%0d_g1", i), 32'(wr1_gnt), 32'(tbl[i].g1));
         check($sformatf("v%0d_vb", i), 32'(vblank_start), 32'(tbl[i].vb));
         check($sformatf("v%0d_addr", i), 32'(mem_addr),
               32'(tbl[i].addr));
         if (tbl[i].we)
            check($sformatf("v%0d_wd", i), 32'(mem_wdata), 32'(tbl[i].wd));
         check($sformatf("v%0d_pv", i), 32'(pix_valid), 32'(tbl[i].pv));
         if (tbl[i].pv && i >= 2)
            check($sformatf("v%0d_pd", i), 32'(pix_data),
                  32'(vhash(tbl[i-2].addr)));
         cyc();
      end

      // Both writers streaming in blanking: strict alternation.
      do_reset();
      row     = 10'd500;
      wr0_req = 1'b1;
      wr1_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("blank%0d_g0", i), 32'(wr0_gnt), 32'(i % 2 == 0));
         check($sformatf("blank%0d_g1", i), 32'(wr1_gnt), 32'(i % 2 == 1));
         check($sformatf("blank%0d_we", i), 32'(mem_we), 1);
         cyc();
      end

      // Active line, one pixel every 2 clocks, writer 1 always asking.
      do_reset();
      row     = 10'd10;
      wr1_req = 1'b1;
      pv_cnt  = 0;
      for (int k = 1; k <= 20; k++) begin
         col = 10'(k);
         @(negedge clk);
         pv_cnt += int'(pix_valid);
         check($sformatf("line%0d_re", k), 32'(mem_re), 1);
         check($sformatf("line%0d_addr", k), 32'(mem_addr), 32'(6400 + k));
         check($sformatf("line%0d_g1a", k), 32'(wr1_gnt), 0);
         cyc();
         @(negedge clk);
         pv_cnt += int'(pix_valid);
         check($sformatf("line%0d_g1b", k), 32'(wr1_gnt), 1);
         check($sformatf("line%0d_reb", k), 32'(mem_re), 0);
         cyc();
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         pv_cnt += int'(pix_valid);
         cyc();
      end
      check("line_pix_count", 32'(pv_cnt), 20);

      // Row 479 -> 480: one vblank pulse, no reads from then on.
      do_reset();
      wr1_req = 1'b0;
      vb_cnt  = 0;
      for (int i = 0; i < 8; i++) begin
         row = (i < 2) ? 10'd479 : 10'd480;
         col = 10'(5 + i);
         @(negedge clk);
         vb_cnt += int'(vblank_start);
         if (i >= 2)
            check($sformatf("vbl%0d_re", i), 32'(mem_re), 0);
         cyc();
      end
      check("vbl_pulse_count", 32'(vb_cnt), 1);

      // Reset lands while a video read is in flight.
      do_reset();
      row     = 10'd2;
      col     = 10'd9;
      wr0_req = 1'b1;
      wr1_req = 1'b1;
      @(negedge clk);
      check("mid_re_before", 32'(mem_re), 1);
      cyc();
      reset = 1'b0;
      #1;
      check("mid_g0", 32'(wr0_gnt), 0);
      check("mid_g1", 32'(wr1_gnt), 0);
      check("mid_we", 32'(mem_we), 0);
      check("mid_re", 32'(mem_re), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("mid%0d_pv", i), 32'(pix_valid), 0);
         check($sformatf("mid%0d_pd", i), 32'(pix_data), 0);
      end

      // Randomized run against the behavioural model.
      do_reset();
      m_col  = 0;
      m_row  = 0;
      m_last = 1;
      m_pix  = 8'h00;
      rowv   = 470;
      colv   = 0;
      moved  = 1'b0;
      w_req[0] = 1'b0;
      w_req[1] = 1'b0;
      pq.delete();
      for (int t = 0; t < 2000; t++) begin
         if (!moved && ($urandom % 2 == 1)) begin
            colv += int'($urandom_range(1, 60));
            if (colv >= 800) begin
               colv = 0;
               rowv = (rowv + 1 >= 525) ? 0 : rowv + 1;
            end
            moved = 1'b1;
         end else begin
            moved = 1'b0;
         end
         for (int k = 0; k < 2; k++) begin
            if (!w_req[k] && ($urandom % 3 == 0)) begin
               w_req[k]  = 1'b1;
               w_addr[k] = 19'($urandom);
               w_data[k] = 8'($urandom);
            end
         end
         row      = 10'(rowv);
         col      = 10'(colv);
         wr0_req  = w_req[0];
         wr0_addr = w_addr[0];
         wr0_data = w_data[0];
         wr1_req  = w_req[1];
         wr1_addr = w_addr[1];
         wr1_data = w_data[1];

         fetch = (colv != m_col) && (rowv < 480) && (colv < 640);
         e_re = fetch;
         e_we = 1'b0;
         e_g0 = 1'b0;
         e_g1 = 1'b0;
         a    = 0;
         win  = -1;
         if (fetch) begin
            a = rowv * 640 + colv;
            pq.push_back('{t + 2, vhash(19'(a))});
         end else if (w_req[0] || w_req[1]) begin
            if (w_req[0] && w_req[1]) win = 1 - m_last;
            else win = w_req[0] ? 0 : 1;
            e_we   = 1'b1;
            e_g0   = (win == 0);
            e_g1   = (win == 1);
            a      = int'(w_addr[win]);
            m_last = win;
         end
         e_vb = (rowv == 480) && (m_row != 480);
         e_pv = (pq.size() > 0) && (pq[0].due == t);
         if (e_pv) m_pix = pq.pop_front().d;

         @(negedge clk);
         check("rnd_re", 32'(mem_re), 32'(e_re));
         check("rnd_we", 32'(mem_we), 32'(e_we));
         check("rnd_g0", 32'(wr0_gnt), 32'(e_g0));
         check("rnd_g1", 32'(wr1_gnt), 32'(e_g1));
         check("rnd_addr", 32'(mem_addr), 32'(a));
         if (e_we)
            check("rnd_wd", 32'(mem_wdata), 32'(w_data[win]));
         check("rnd_vb", 32'(vblank_start), 32'(e_vb));
         check("rnd_pv", 32'(pix_valid), 32'(e_pv));
         check("rnd_pd", 32'(pix_data), 32'(m_pix));

         if (win >= 0) w_req[win] = 1'b0;
         m_col = colv;
         m_row = rowv;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
